// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage scoreboard hazard unit: result latencies,
// consumer slack values and default geometry.
package hazard_pkg;

  localparam int REG_AW_DEF  = 6;
  localparam int MAX_LAT_DEF = 4;

  // Cycles from issue until the result can be forwarded to an ID-stage consumer
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;

  // A consumer in EX gets one extra cycle of forwarding reach compared to ID
  localparam int SLACK_ID = 0;
  localparam int SLACK_EX = 1;

  function automatic int cnt_width(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One tracked register's result-availability countdown. A clear (flush of the
// ID/EX entry) beats a load, and a load beats the per-cycle decrement.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CNT_W = cnt_width(MAX_LAT_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] lat,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = lat;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: stalls on RAW (source not yet forwardable) and WAW
// (write would overtake an older pending write), cancels the ID/EX entry on flush.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MAX_LAT     = MAX_LAT_DEF,
  parameter int CNT_W       = $clog2(MAX_LAT + 1),
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_reg_write,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic [CNT_W-1:0]       issue_lat,
  input  logic [REG_AW-1:0]      rs,
  input  logic [REG_AW-1:0]      rt,
  input  logic                   rs_valid,
  input  logic                   rt_valid,
  input  logic                   rs_early,
  input  logic                   rt_early,
  input  logic                   flush,
  output logic                   stall,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   sb_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0][CNT_W-1:0] cnt_vec;
  logic [NREG-1:1]            nz_vec;
  logic [NREG-1:1]            load_vec;
  logic [NREG-1:1]            clear_vec;

  logic [CNT_W-1:0] eff_lat;
  logic [CNT_W-1:0] rs_slack;
  logic [CNT_W-1:0] rt_slack;
  logic             raw_rs;
  logic             raw_rt;
  logic             waw;
  logic             issue_fire;

  logic                   last_valid_q, last_valid_d;
  logic [REG_AW-1:0]      last_rd_q, last_rd_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  // Register 0 is hard-wired to "available" so r0 never causes a hazard
  assign cnt_vec[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    hazard_sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk    (clk),
      .rst    (rst),
      .load   (load_vec[r]),
      .lat    (eff_lat),
      .clear  (clear_vec[r]),
      .cnt    (cnt_vec[r]),
      .nonzero(nz_vec[r])
    );
  end

  always_comb begin
    eff_lat  = (issue_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : issue_lat;
    rs_slack = rs_early ? CNT_W'(SLACK_ID) : CNT_W'(SLACK_EX);
    rt_slack = rt_early ? CNT_W'(SLACK_ID) : CNT_W'(SLACK_EX);
    raw_rs   = rs_valid && (rs != '0) && (cnt_vec[rs] > rs_slack);
    raw_rt   = rt_valid && (rt != '0) && (cnt_vec[rt] > rt_slack);
    waw      = issue_reg_write && (issue_rd != '0) && (cnt_vec[issue_rd] > eff_lat);
    // Flush must never stall so the PC is free to load the vector
    stall      = issue_valid && !flush && (raw_rs || raw_rt || waw);
    issue_fire = issue_valid && !flush && !stall;
  end

  always_comb begin
    load_vec  = '0;
    clear_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      load_vec[r]  = issue_fire && issue_reg_write && (issue_rd == REG_AW'(r))
                     && (eff_lat != '0);
      clear_vec[r] = flush && last_valid_q && (last_rd_q == REG_AW'(r));
    end
  end

  // Only a register-writing issue leaves an entry that a flush may cancel
  always_comb begin
    last_valid_d  = issue_fire && issue_reg_write;
    last_rd_d     = issue_rd;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid_q  <= 1'b0;
      last_rd_q     <= '0;
      stall_count_q <= '0;
    end else begin
      last_valid_q  <= last_valid_d;
      last_rd_q     <= last_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign sb_busy     = |nz_vec;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline scenarios plus
// random traffic, each cycle's expected outputs taken from a countdown model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int REG_AW  = 6;
  localparam int MAX_LAT = 4;
  localparam int CNT_W   = 3;
  // Narrow stall counter so its saturation is reached in a few thousand cycles
  localparam int SC_W    = 12;
  localparam int SC_MAX  = (1 << SC_W) - 1;
  localparam int NREG    = 1 << REG_AW;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic              issue_reg_write;
  logic [REG_AW-1:0] issue_rd;
  logic [CNT_W-1:0]  issue_lat;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              rs_valid;
  logic              rt_valid;
  logic              rs_early;
  logic              rt_early;
  logic              flush;
  logic              stall;
  logic              pc_write;
  logic              if_id_write;
  logic              sb_busy;
  logic [SC_W-1:0]   stall_count;

  hazard_scoreboard #(
    .REG_AW     (REG_AW),
    .MAX_LAT    (MAX_LAT),
    .CNT_W      (CNT_W),
    .STALL_CNT_W(SC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_reg_write(issue_reg_write),
    .issue_rd       (issue_rd),
    .issue_lat      (issue_lat),
    .rs             (rs),
    .rt             (rt),
    .rs_valid       (rs_valid),
    .rt_valid       (rt_valid),
    .rs_early       (rs_early),
    .rt_early       (rt_early),
    .flush          (flush),
    .stall          (stall),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .sb_busy        (sb_busy),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit stall;
    bit busy;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: remaining cycles until each register is forwardable to ID
  int m_cnt[NREG];
  bit m_last_valid;
  int m_last_rd;
  int m_stall_count;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("stall", int'(stall), int'(e.stall));
      checkOutput("pc_write", int'(pc_write), int'(!e.stall));
      checkOutput("if_id_write", int'(if_id_write), int'(!e.stall));
      checkOutput("sb_busy", int'(sb_busy), int'(e.busy));
      checkOutput("stall_count", int'(stall_count), e.count);
    end
  end

  function automatic int effLat();
    return (int'(issue_lat) > MAX_LAT) ? MAX_LAT : int'(issue_lat);
  endfunction

  function automatic bit modelStall();
    int  rs_need = rs_early ? 0 : 1;
    int  rt_need = rt_early ? 0 : 1;
    bit  hazard  = 1'b0;
    if (rs_valid && rs != 0 && m_cnt[rs] > rs_need) hazard = 1'b1;
    if (rt_valid && rt != 0 && m_cnt[rt] > rt_need) hazard = 1'b1;
    if (issue_reg_write && issue_rd != 0 && m_cnt[issue_rd] > effLat()) hazard = 1'b1;
    return issue_valid && !flush && hazard;
  endfunction

  function automatic bit modelBusy();
    for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelClear();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_last_valid  = 1'b0;
    m_last_rd     = 0;
    m_stall_count = 0;
  endtask

  // One ID-stage cycle: drive inputs, record expectation, advance the model
  task automatic applyStimulus(input bit v, input bit wr, input int rd, input int lat,
                               input int rs_i, input bit rsv, input bit rse,
                               input int rt_i, input bit rtv, input bit rte,
                               input bit fl, output bit stalled);
    exp_t e;
    int   nxt[NREG];
    int   eff;
    bit   fire;
    @(posedge clk);
    #1;
    rst             = 1'b0;
    issue_valid     = v;
    issue_reg_write = wr;
    issue_rd        = REG_AW'(rd);
    issue_lat       = CNT_W'(lat);
    rs              = REG_AW'(rs_i);
    rs_valid        = rsv;
    rs_early        = rse;
    rt              = REG_AW'(rt_i);
    rt_valid        = rtv;
    rt_early        = rte;
    flush           = fl;
    stalled = modelStall();
    e.stall = stalled;
    e.busy  = modelBusy();
    e.count = m_stall_count;
    exp_q.push_back(e);
    eff  = effLat();
    fire = v && !fl && !stalled;
    for (int r = 1; r < NREG; r++) begin
      if (fl && m_last_valid && m_last_rd == r) nxt[r] = 0;
      else if (fire && wr && rd == r && eff != 0) nxt[r] = eff;
      else nxt[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    end
    for (int r = 1; r < NREG; r++) m_cnt[r] = nxt[r];
    m_last_valid = fire && wr;
    m_last_rd    = rd;
    if (stalled && m_stall_count < SC_MAX) m_stall_count++;
  endtask

  // Reset asserted mid-cycle for two cycles; outputs must collapse immediately
  task automatic doReset();
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelClear();
    e.stall = 1'b0;
    e.busy  = 1'b0;
    e.count = 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
  endtask

  task automatic issueWrite(input int rd, input int lat);
    bit s;
    applyStimulus(1, 1, rd, lat, 0, 0, 0, 0, 0, 0, 0, s);
  endtask

  // Hold one instruction in ID until the model lets it issue (bounded)
  task automatic holdUntilIssue(input bit wr, input int rd, input int lat,
                                input int src, input bit early);
    bit s;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, wr, rd, lat, src, 1, early, 0, 0, 0, 0, s);
      if (!s) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit s;
    bit held;
    bit v, wr, rsv, rse, rtv, rte, fl;
    int rd, lat, rs_i, rt_i;
    int lat_tab[9] = '{0, 1, 1, 2, 2, 4, 4, 5, 7};

    rst = 1'b1;
    issue_valid = 0; issue_reg_write = 0; issue_rd = '0; issue_lat = '0;
    rs = '0; rt = '0; rs_valid = 0; rt_valid = 0; rs_early = 0; rt_early = 0;
    flush = 0;
    modelClear();
    doReset();

    // ALU then EX consumer, load-use, load-then-branch
    issueWrite(5, LAT_ALU);
    holdUntilIssue(0, 0, 0, 5, 0);
    idle(3);
    issueWrite(5, LAT_LOAD);
    holdUntilIssue(0, 0, 0, 5, 0);
    idle(3);
    issueWrite(5, LAT_LOAD);
    holdUntilIssue(0, 0, 0, 5, 1);
    idle(3);

    // WAW: MUL then ALU to the same destination, and an over-range latency
    issueWrite(7, LAT_MUL);
    holdUntilIssue(1, 7, LAT_ALU, 0, 0);
    idle(5);
    issueWrite(3, 7);
    holdUntilIssue(0, 0, 0, 3, 1);
    idle(5);

    // Flush cancels the ID/EX load, the replayed consumer then flows
    issueWrite(5, LAT_LOAD);
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, s);
    holdUntilIssue(0, 0, 0, 5, 0);
    idle(2);

    // r0 never stalls, and lat 0 creates no entry
    issueWrite(0, LAT_MUL);
    applyStimulus(1, 1, 0, LAT_MUL, 0, 1, 1, 0, 1, 1, 0, s);
    issueWrite(6, 0);
    holdUntilIssue(0, 0, 0, 6, 1);
    idle(2);

    // Reset while r9 still has three cycles to go
    issueWrite(9, 3);
    doReset();
    holdUntilIssue(0, 0, 0, 9, 1);
    idle(2);

    // Random traffic over a few registers; stalled instructions are held
    held = 1'b0;
    v = 0; wr = 0; rd = 0; lat = 0; rs_i = 0; rt_i = 0;
    rsv = 0; rse = 0; rtv = 0; rte = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        doReset();
        held = 1'b0;
      end
      if (!held) begin
        v    = ($urandom_range(99) < 85);
        wr   = $urandom_range(1);
        rd   = $urandom_range(7);
        lat  = lat_tab[$urandom_range(8)];
        rs_i = $urandom_range(7);
        rt_i = $urandom_range(7);
        rsv  = $urandom_range(1);
        rtv  = $urandom_range(1);
        rse  = ($urandom_range(3) == 0);
        rte  = ($urandom_range(3) == 0);
      end
      fl = ($urandom_range(99) < 6);
      applyStimulus(v, wr, rd, lat, rs_i, rsv, rse, rt_i, rtv, rte, fl, s);
      held = s;
    end

    // Self-dependent MUL chain keeps stalling until the counter saturates
    doReset();
    for (int i = 0; i < 5400; i++) begin
      applyStimulus(1, 1, 9, LAT_MUL, 9, 1, 1, 0, 0, 0, 0, s);
    end
    idle(2);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
